// File: rtl/rv32_mod_fetch_if.sv
// Fetch-stage bus: branch redirect input, instruction-memory port and decode handshake.
// The master modport is the fetch stage's view; slave is the surrounding pipeline/memory.
interface rv32_mod_fetch_if;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_len4;

   modport master (
      input  branch_taken, branch_target, imem_ack, imem_rdata, instr_ready,
      output imem_req, imem_addr, instr_valid, instr, instr_pc, instr_len4
   );

   modport slave (
      output branch_taken, branch_target, imem_ack, imem_rdata, instr_ready,
      input  imem_req, imem_addr, instr_valid, instr, instr_pc, instr_len4
   );
endinterface

// File: rtl/rv32_mod_fetch.sv
// rv32imc instruction fetch: owns the PC, issues one imem request at a time and
// delivers instructions to decode through a single output register.
module rv32_mod_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rst,
   rv32_mod_fetch_if.master       fetch_bus
);

   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:1], 1'b0};

   typedef enum logic {
      S_BOOT,
      S_RUN
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        w_started;

   logic [31:0] r_pc;
   logic        r_valid;
   logic [31:0] r_instr;
   logic [31:0] r_instr_pc;
   logic        r_len4;

   logic        w_req;
   logic        w_fire;
   logic        w_len4;
   logic [31:0] w_pc_inc;
   logic        w_unused_target_bit0;

   assign w_unused_target_bit0 = fetch_bus.branch_target[0];

   // Boot state holds off the first request for one cycle after reset release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_BOOT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_started   = 1'b0;
      case (r_state)
         S_BOOT: begin
            w_state_nxt = S_RUN;
         end
         S_RUN: begin
            w_started   = 1'b1;
         end
         default: begin
            w_state_nxt = S_BOOT;
         end
      endcase
   end

   always_comb begin
      w_req    = w_started & ~fetch_bus.branch_taken & (~r_valid | fetch_bus.instr_ready);
      w_fire   = w_req & fetch_bus.imem_ack;
      w_len4   = (fetch_bus.imem_rdata[1:0] == 2'b11);
      w_pc_inc = w_len4 ? 32'd4 : 32'd2;
   end

   // Redirect outranks everything: it discards the buffered instruction even if decode is ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc       <= RESET_PC_ALIGNED;
         r_valid    <= 1'b0;
         r_instr    <= '0;
         r_instr_pc <= '0;
         r_len4     <= 1'b0;
      end else if (fetch_bus.branch_taken) begin
         r_pc       <= {fetch_bus.branch_target[31:1], 1'b0};
         r_valid    <= 1'b0;
      end else if (w_fire) begin
         r_pc       <= r_pc + w_pc_inc;
         r_valid    <= 1'b1;
         r_instr    <= fetch_bus.imem_rdata;
         r_instr_pc <= r_pc;
         r_len4     <= w_len4;
      end else if (fetch_bus.instr_ready) begin
         r_valid    <= 1'b0;
      end
   end

   assign fetch_bus.imem_req    = w_req;
   assign fetch_bus.imem_addr   = r_pc;
   assign fetch_bus.instr_valid = r_valid;
   assign fetch_bus.instr       = r_instr;
   assign fetch_bus.instr_pc    = r_instr_pc;
   assign fetch_bus.instr_len4  = r_len4;

endmodule
